// File: rtl/lzc_pkg.sv
// Shared types and width helpers for the pipelined zero counter.
package lzc_pkg;

  typedef enum logic {
    LZC_LEAD  = 1'b0,
    LZC_TRAIL = 1'b1
  } lzc_mode_e;

  // Operand width rounded up to the next power of two (tree width).
  function automatic int lzc_pad_w(input int w);
    return 1 << $clog2(w);
  endfunction

  function automatic int lzc_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero tree over a power-of-two width; built recursively
// from 2-bit leaves. The output MSB set means "all bits zero".
module lzc_tree #(
  parameter int P = 16
) (
  input  logic [P-1:0]      x,
  output logic [$clog2(P):0] cnt
);

  if (P == 2) begin : g_leaf
    assign cnt = {~x[1] & ~x[0], ~x[1] & x[0]};
  end else begin : g_node
    localparam int K = $clog2(P);
    logic [K-1:0] cnt_l;
    logic [K-1:0] cnt_r;

    lzc_tree #(.P(P / 2)) u_left  (.x(x[P-1:P/2]), .cnt(cnt_l));
    lzc_tree #(.P(P / 2)) u_right (.x(x[P/2-1:0]), .cnt(cnt_r));

    // Left half empty: count = half width + right count.
    assign cnt = {cnt_l[K-1] & cnt_r[K-1],
                  cnt_l[K-1] & ~cnt_r[K-1],
                  cnt_l[K-1] ? cnt_r[K-2:0] : cnt_l[K-2:0]};
  end

endmodule

// File: rtl/lzc_pipe.sv
// Three-stage leading/trailing zero counter with normalising shift and a
// valid/ready stall chain (capture, count, normalise).
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = lzc_cnt_w(W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [W-1:0]     data_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [W-1:0]     norm_o,
  output logic             zero_o,
  output logic             mode_o
);

  localparam int P  = lzc_pad_w(W);
  localparam int TW = $clog2(P) + 1;

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  logic             en1, en2, en3;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [W-1:0]     d1_q, d1_d, d2_q, d2_d, norm3_q, norm3_d;
  lzc_mode_e        m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d, cnt3_q, cnt3_d;
  logic             zero2_q, zero2_d, zero3_q, zero3_d;
  logic [P-1:0]     pad;
  logic [TW-1:0]    tree_cnt;

  // Ones appended below the LSB stop the count at W for a zero operand.
  always_comb begin
    pad            = '1;
    pad[P-1 -: W]  = d1_q;
  end

  lzc_tree #(.P(P)) u_tree (.x(pad), .cnt(tree_cnt));

  always_comb begin
    en3     = ~v3_q | ready_i;
    en2     = ~v2_q | en3;
    en1     = ~v1_q | en2;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    d1_d    = d1_q;
    m1_d    = m1_q;
    d2_d    = d2_q;
    m2_d    = m2_q;
    cnt2_d  = cnt2_q;
    zero2_d = zero2_q;
    norm3_d = norm3_q;
    cnt3_d  = cnt3_q;
    zero3_d = zero3_q;
    m3_d    = m3_q;

    if (en1) v1_d = valid_i;
    if (en1 && valid_i) begin
      d1_d = (mode_i == LZC_TRAIL) ? bit_rev(data_i) : data_i;
      m1_d = lzc_mode_e'(mode_i);
    end

    if (en2) v2_d = v1_q;
    if (en2 && v1_q) begin
      d2_d    = (m1_q == LZC_TRAIL) ? bit_rev(d1_q) : d1_q;
      m2_d    = m1_q;
      cnt2_d  = CNT_W'(tree_cnt);
      zero2_d = (tree_cnt == TW'(W));
    end

    if (en3) v3_d = v2_q;
    if (en3 && v2_q) begin
      norm3_d = (m2_q == LZC_TRAIL) ? (d2_q >> cnt2_q) : (d2_q << cnt2_q);
      cnt3_d  = cnt2_q;
      zero3_d = zero2_q;
      m3_d    = m2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      d1_q    <= '0;
      m1_q    <= LZC_LEAD;
      d2_q    <= '0;
      m2_q    <= LZC_LEAD;
      cnt2_q  <= '0;
      zero2_q <= 1'b0;
      norm3_q <= '0;
      cnt3_q  <= '0;
      zero3_q <= 1'b0;
      m3_q    <= LZC_LEAD;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      d1_q    <= d1_d;
      m1_q    <= m1_d;
      d2_q    <= d2_d;
      m2_q    <= m2_d;
      cnt2_q  <= cnt2_d;
      zero2_q <= zero2_d;
      norm3_q <= norm3_d;
      cnt3_q  <= cnt3_d;
      zero3_q <= zero3_d;
      m3_q    <= m3_d;
    end
  end

  assign ready_o = en1;
  assign valid_o = v3_q;
  assign cnt_o   = cnt3_q;
  assign norm_o  = norm3_q;
  assign zero_o  = zero3_q;
  assign mode_o  = m3_q;

endmodule
